// File: rtl/inert_poll_pkg.sv
// inert_poll_pkg: sequencer state encoding, SPI init list and channel address map.
package inert_poll_pkg;

  typedef enum logic [1:0] {PWR_DLY, INIT_XFER, WAIT_INT, RD_XFER} state_t;

  localparam int unsigned NUM_INIT = 4;
  localparam logic        READ_BIT = 1'b1;

  localparam logic [15:0] INIT_CMDS [NUM_INIT] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  localparam logic [6:0]  CH_ADDR_L [8] = '{7'h24, 7'h26, 7'h2A, 7'h2C, 7'h20, 7'h22, 7'h28, 7'h2E};

  // Byte b reads channel b>>1; odd bytes address the high register (low + 1, wraps mod 128).
  function automatic logic [15:0] rd_cmd(input logic [3:0] b);
    logic [6:0] addr;
    addr = CH_ADDR_L[b[3:1]] + {6'd0, b[0]};
    return {READ_BIT, addr, 8'h00};
  endfunction

endpackage

// File: rtl/inert_poll_seq_sync.sv
// inert_int_sync: two-flop synchroniser for the sensor INT line, with rising-edge strobe.
module inert_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync,
  output logic rise
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/inert_poll_seq.sv
// inert_poll_seq: SPI init list after power-up, then NUM_CH-channel burst read per sensor INT.
// Optional INT watchdog (to_err, init restart) enabled by defining INERT_POLL_WDOG_EN.
module inert_poll_seq
  import inert_poll_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PWR_DLY_W = 16,
  parameter int unsigned TO_W      = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 INT,
  output logic                 snd,
  output logic [15:0]          cmd,
  input  logic                 done,
  input  logic [15:0]          resp,
  output logic [16*NUM_CH-1:0] ch_data,
  output logic                 vld,
  output logic                 ovr,
  input  logic                 ovr_clr,
  output logic                 to_err,
  output logic                 init_done
);

  localparam int unsigned     B_W      = $clog2(2 * NUM_CH);
  localparam logic [B_W-1:0]  B_LAST   = B_W'(2 * NUM_CH - 1);
  localparam logic [1:0]      IDX_LAST = 2'(NUM_INIT - 1);

  state_t               state;
  logic [PWR_DLY_W-1:0] pwr_cnt;
  logic [1:0]           idx;
  logic [B_W-1:0]       b;
  logic [16*NUM_CH-1:0] stage;
  logic                 upd;
  logic                 int_lvl;
  logic                 int_rise;
  logic                 unused_ok;

  assign unused_ok = &{1'b0, resp[15:8]};

  inert_int_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (INT),
    .sync     (int_lvl),
    .rise     (int_rise)
  );

`ifdef INERT_POLL_WDOG_EN
  logic [TO_W-1:0] wd_cnt;
`else
  localparam int unsigned TO_W_UNUSED = TO_W;
  assign to_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWR_DLY;
      pwr_cnt   <= '0;
      idx       <= '0;
      b         <= '0;
      stage     <= '0;
      upd       <= 1'b0;
      ch_data   <= '0;
      vld       <= 1'b0;
      ovr       <= 1'b0;
      init_done <= 1'b0;
      snd       <= 1'b0;
      cmd       <= '0;
`ifdef INERT_POLL_WDOG_EN
      wd_cnt    <= '0;
      to_err    <= 1'b0;
`endif
    end else begin
      snd <= 1'b0;
      upd <= 1'b0;
      vld <= upd;
      // Staging is copied only after the last byte, so ch_data never shows a partial set.
      if (upd)
        ch_data <= stage;

      if (ovr_clr)
        ovr <= 1'b0;
      else if (int_rise && state == RD_XFER && init_done)
        ovr <= 1'b1;

`ifdef INERT_POLL_WDOG_EN
      wd_cnt <= '0;
`endif

      case (state)
        PWR_DLY: begin
          pwr_cnt <= pwr_cnt + 1'b1;
          if (&pwr_cnt) begin
            snd   <= 1'b1;
            cmd   <= INIT_CMDS[0];
            idx   <= '0;
            state <= INIT_XFER;
          end
        end
        INIT_XFER: begin
          if (done) begin
            if (idx != IDX_LAST) begin
              idx <= idx + 1'b1;
              snd <= 1'b1;
              cmd <= INIT_CMDS[idx + 2'd1];
            end else begin
              init_done <= 1'b1;
              state     <= WAIT_INT;
            end
          end
        end
        WAIT_INT: begin
          if (int_lvl) begin
            snd   <= 1'b1;
            cmd   <= rd_cmd(4'd0);
            b     <= '0;
            state <= RD_XFER;
          end
`ifdef INERT_POLL_WDOG_EN
          else if (&wd_cnt) begin
            to_err    <= 1'b1;
            init_done <= 1'b0;
            idx       <= '0;
            snd       <= 1'b1;
            cmd       <= INIT_CMDS[0];
            state     <= INIT_XFER;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RD_XFER: begin
          if (done) begin
            stage[8*b +: 8] <= resp[7:0];
            if (b != B_LAST) begin
              b   <= b + 1'b1;
              snd <= 1'b1;
              cmd <= rd_cmd(4'(b + 1'b1));
            end else begin
              upd   <= 1'b1;
              state <= WAIT_INT;
            end
          end
        end
        default: state <= PWR_DLY;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_poll_seq.sv
// Directed bench for inert_poll_seq with a fixed-latency SPI master model.
module tb_inert_poll_seq;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned PWR_DLY_W = 4;
  localparam int unsigned TO_W      = 6;
  localparam int          SPI_DLY   = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 INT = 1'b0;
  logic                 snd;
  logic [15:0]          cmd;
  logic                 done = 1'b0;
  logic [15:0]          resp = '0;
  logic [16*NUM_CH-1:0] ch_data;
  logic                 vld;
  logic                 ovr;
  logic                 ovr_clr = 1'b0;
  logic                 to_err;
  logic                 init_done;

  int total = 0;
  int bad   = 0;

  logic [15:0] cmd_log [$];
  logic [15:0] cur_cmd = '0;
  int  busy = 0, cnt = 0, n_done = 0, n_rd = 0, overlap = 0;
  bit  force_done = 1'b0;
  logic prev_init = 1'b0;

  logic [15:0] init_exp [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [7:0]  rd_hi    [8] = '{8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hAA, 8'hAB, 8'hAC, 8'hAD};
  logic [63:0] burst_exp = 64'h8877_6655_4433_2211;

  inert_poll_seq #(.NUM_CH(NUM_CH), .PWR_DLY_W(PWR_DLY_W), .TO_W(TO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (INT),
    .snd       (snd),
    .cmd       (cmd),
    .done      (done),
    .resp      (resp),
    .ch_data   (ch_data),
    .vld       (vld),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr),
    .to_err    (to_err),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // SPI master: done 8 cycles after snd; reads return 0x11,0x22,...,0x88 with junk upper byte.
  always @(negedge clk) begin
    logic [7:0] rb;
    done = 1'b0;
    if (rst) begin
      busy = 0;
      cnt  = 0;
      n_rd = 0;
    end else begin
      if (busy != 0) begin
        if (cnt == 1) begin
          busy = 0;
          done = 1'b1;
          n_done++;
          if (cur_cmd[15]) begin
            rb   = 8'(((n_rd % 8) + 1) * 17);
            resp = {8'hEE, rb};
            n_rd++;
          end else begin
            resp = 16'hEEEE;
          end
        end else begin
          cnt--;
        end
      end else if (force_done) begin
        done       = 1'b1;
        force_done = 1'b0;
      end
      if (snd) begin
        if (busy != 0) overlap++;
        cmd_log.push_back(cmd);
        cur_cmd = cmd;
        busy    = 1;
        cnt     = SPI_DLY;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    prev_init = init_done;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_snd(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (snd !== 1'b1 && cyc < 5000);
  endtask

  task automatic wait_done(input int target, output bit ok);
    int k = 0;
    while (n_done < target && k < 3000) begin
      tick();
      k++;
    end
    ok = (n_done >= target);
  endtask

  task automatic wait_rd(input int target, output bit ok);
    int k = 0;
    while (n_rd < target && k < 3000) begin
      tick();
      k++;
    end
    ok = (n_rd >= target);
  endtask

  task automatic wait_log(input int target, output bit ok);
    int k = 0;
    while (cmd_log.size() < target && k < 3000) begin
      tick();
      k++;
    end
    ok = (cmd_log.size() >= target);
  endtask

  task automatic check_burst_cmds(input int base);
    for (int i = 0; i < 8; i++)
      check($sformatf("rd_cmd%0d", i), cmd_log[base + i], {rd_hi[i], 8'h00});
  endtask

  initial begin
    int cyc;
    bit ok;
    int base;
    int rbase;
    int seen;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_snd", snd, 0);
    check("rst_cmd", cmd, 0);
    check("rst_ch_data", ch_data, 0);
    check("rst_flags", {vld, ovr, to_err, init_done}, 0);
    rst = 1'b0;

    // Power-up delay is 2^PWR_DLY_W = 16 clocks before the first snd.
    wait_snd(cyc);
    check("pwr_dly_cycles", cyc, 16);
    check("first_init_cmd", cmd, 16'h0D02);

    wait_done(4, ok);
    check("init_dones", ok, 1);
    check("init_done_rise", {prev_init, init_done}, 2'b01);
    check("init_log_len", cmd_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("init_cmd%0d", i), cmd_log[i], init_exp[i]);

`ifdef INERT_POLL_WDOG_EN
    // No INT: 64 WAIT_INT cycles, then the init list restarts.
    wait_snd(cyc);
    check("wdog_cycles", cyc, 64);
    check("wdog_to_err", to_err, 1);
    check("wdog_init_done", init_done, 0);
    check("wdog_cmd", cmd, 16'h0D02);
    wait_done(8, ok);
    check("wdog_reinit", {ok, init_done, to_err}, 3'b111);
`else
    seen = 0;
    repeat (100) begin
      tick();
      if (snd === 1'b1) seen++;
    end
    check("idle_no_snd", seen, 0);
    check("idle_to_err", to_err, 0);

    // Burst 1: single INT pulse.
    base  = cmd_log.size();
    rbase = n_rd;
    INT = 1'b1;
    repeat (3) tick();
    INT = 1'b0;
    wait_rd(rbase + 8, ok);
    check("b1_reads", ok, 1);
    check("b1_vld_early", vld, 0);
    check("b1_no_partial", ch_data, 0);
    tick();
    check("b1_vld", vld, 1);
    check("b1_ch_data", ch_data, burst_exp);
    check("b1_ovr", ovr, 0);
    tick();
    check("b1_vld_pulse", vld, 0);
    check_burst_cmds(base);

    // done while idle must be ignored.
    base = cmd_log.size();
    force_done = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (snd === 1'b1 || vld === 1'b1) seen++;
    end
    check("spurious_done", seen, 0);

    // Burst 2: INT rises again during the 3rd byte and stays high.
    base  = cmd_log.size();
    rbase = n_rd;
    INT = 1'b1;
    repeat (3) tick();
    INT = 1'b0;
    wait_log(base + 3, ok);
    check("b2_third_byte", ok, 1);
    repeat (4) tick();
    INT = 1'b1;
    repeat (6) tick();
    check("ovr_set", ovr, 1);
    wait_rd(rbase + 8, ok);
    check("b2_reads", ok, 1);
    tick();
    check("b2_vld", vld, 1);
    check("b2_ch_data", ch_data, burst_exp);
    check("reburst_snd", snd, 1);
    check("reburst_cmd", cmd, 16'hA400);
    check("ovr_held", ovr, 1);
    INT = 1'b0;
    check_burst_cmds(base);

    // Burst 3 (re-triggered): ovr_clr coincides with a fresh INT edge.
    base  = cmd_log.size() - 1;
    rbase = n_rd;
    wait_log(base + 3, ok);
    check("b3_progress", ok, 1);
    INT = 1'b1;
    tick();
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr_prio", ovr, 0);
    INT = 1'b0;
    repeat (4) tick();
    check("ovr_stays_clr", ovr, 0);
    wait_rd(rbase + 8, ok);
    tick();
    check("b3_vld", {ok, vld}, 2'b11);
    check("b3_ch_data", ch_data, burst_exp);

    // Reset during the 5th byte of burst 4.
    repeat (5) tick();
    base = cmd_log.size();
    INT = 1'b1;
    repeat (3) tick();
    INT = 1'b0;
    wait_log(base + 5, ok);
    check("b4_fifth_byte", ok, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_snd_cmd", {snd, cmd}, 0);
    check("mid_rst_ch_data", ch_data, 0);
    check("mid_rst_flags", {vld, ovr, to_err, init_done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_snd(cyc);
    check("re_pwr_dly", cyc, 16);
    check("re_init_cmd", cmd, 16'h0D02);
    check("re_ch_data", ch_data, 0);
`endif

    check("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
